uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_pkg.sv | 22 ++
 rtl/uart_rx_ctrl_edge_det.sv | 34 +++
 rtl/uart_rx_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_t   : receive FSM state encoding (binary)
//   IDX_*        : bit indices reported by bps_rx on rx_num
//   DATA_BITS    : payload bits per frame
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    WAIT_END = 3'd4
  } rx_state_t;

  localparam int         DATA_BITS      = 8;
  localparam logic [3:0] IDX_START      = 4'd0;
  localparam logic [3:0] IDX_FIRST_DATA = 4'd1;
  localparam logic [3:0] IDX_LAST_DATA  = 4'(DATA_BITS);
  localparam logic [3:0] IDX_STOP       = 4'd9;
  localparam logic [3:0] IDX_END        = 4'd10;

endpackage

// File: rtl/uart_rx_ctrl_edge_det.sv
// rx_edge_det: multi-flop synchronizer for the asynchronous serial line
// followed by a history flop used to detect a falling edge.
//   clk   : system clock
//   rst_n : synchronous active-low reset (all flops preset to idle-high)
//   din   : raw asynchronous line
//   dout  : synchronized line
//   fall  : high for one cycle when the synchronized line goes 1 -> 0
module rx_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign fall = hist_q & ~dout;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller (8N1, LSB first). Detects the start
// edge, launches the external bit-rate generator (bps_rx) and samples the
// line on its mid-bit strobes, delivering framed bytes.
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   rs232_rx    : asynchronous serial input, idle high
//   rx_sel_data : mid-bit sample strobe from bps_rx
//   rx_num      : bit index from bps_rx (0 start, 1..8 data, 9 stop, 10 end)
//   rx_en       : one-cycle pulse starting bps_rx
//   rx_data     : last correctly framed byte
//   rx_valid    : one-cycle pulse when rx_data updates
//   frame_err   : one-cycle pulse when the stop bit samples 0
//   rx_busy     : high while the FSM is outside IDLE
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  input  logic       rx_sel_data,
  input  logic [3:0] rx_num,
  output logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  rx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_d;
  logic                 en_d, valid_d, ferr_d;
  logic                 line, fall;
  logic [2:0]           bit_idx;

  rx_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (rs232_rx),
    .dout (line),
    .fall (fall)
  );

  // Data bit k lands in shift bit k-1; only used when rx_num is 1..8.
  assign bit_idx = 3'(rx_num - IDX_FIRST_DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      rx_data   <= 8'h00;
      rx_en     <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_en     <= en_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      // Registered from the next state so busy rises together with rx_en.
      rx_busy   <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = rx_data;
    en_d    = 1'b0;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          en_d    = 1'b1;
          state_d = START;
        end
      end

      START: begin
        // A line already back high at mid start bit was a glitch: let the
        // bit-rate generator run out its frame, but report nothing.
        if (rx_sel_data && rx_num == IDX_START)
          state_d = line ? WAIT_END : DATA;
      end

      DATA: begin
        if (rx_sel_data && rx_num >= IDX_FIRST_DATA && rx_num <= IDX_LAST_DATA) begin
          shift_d[bit_idx] = line;
          if (rx_num == IDX_LAST_DATA)
            state_d = STOP;
        end
      end

      STOP: begin
        if (rx_sel_data && rx_num == IDX_STOP) begin
          if (line) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
          state_d = WAIT_END;
        end
      end

      WAIT_END: begin
        // Level check, no strobe: bps_rx holds rx_num==10 for one cycle.
        if (rx_num == IDX_END)
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
